clk_divider_prog: RTL and testbench
===================================

Name: clk_divider_prog

Overview:
- Runtime-programmable successor to the fixed divide-by-2 speech clock divider: generates the PDM microphone clock from clk_in using a DIV_W-bit divisor.
- Runs entirely in fabric logic with a registered clk_out, and also provides single-cycle rise and fall strobes for downstream logic clocked by clk_in.
- Adds a frame strobe every frame_len output periods, used to mark decimation and feature frames in the speech pipeline.
- Divisor changes take effect only at a period boundary, so clk_out never glitches.

Parameters:
- DIV_W, 8, width of the divisor.
- DIV_DEFAULT, 2, divisor after reset. Values below 2 are clamped to 2.
- FRAME_W, 16, width of the frame length.
- FRAME_DEFAULT, 256, frame length after reset. 0 is treated as 1.

Ports:
- clk_in  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the clk_in rising edge.
- enable  in  1  1 = run; 0 = freeze all state.
- div_value  in  DIV_W  requested divisor N.
- div_load  in  1  1-cycle request to capture div_value.
- div_busy  out  1  a captured divisor is pending application.
- frame_len  in  FRAME_W  output periods per frame.
- clk_out  out  1  registered divided clock.
- rise_tick  out  1  high in the cycle clk_out goes 0->1.
- fall_tick  out  1  high in the cycle clk_out goes 1->0.
- frame_tick  out  1  coincides with the rise_tick that closes a frame.

Behaviour:
- Reset (reset=0 at an edge) sets:
  - cnt = N0-1, where N0 = max(DIV_DEFAULT,2).
  - active N = N0.
  - clk_out=0, rise_tick=0, fall_tick=0, frame_tick=0, div_busy=0.
  - pending divisor cleared; frame_cnt=0; L = FRAME_DEFAULT (0 -> 1).
- Reset mid-operation discards any pending divisor and restarts from this state. The first enabled cycle afterwards produces a rise.
- Divisor clamping: eff(x) = x if x >= 2, else 2. High time H = (N+1)>>1, giving 50% duty for even N; for odd N the high phase is one cycle longer.
- Each enabled cycle:
  - cnt_next = (cnt == N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < H).
  - rise_tick <= (cnt_next == 0).
  - fall_tick <= (cnt_next == H).
  - All outputs are registered; the ticks are aligned with the clk_out edge they describe.
- enable=0: cnt, clk_out, frame_cnt and the pending divisor hold. Ticks are driven 0. div_load is still accepted.
- Load handshake:
  - div_load=1 while div_busy=0: capture pending = eff(div_value); div_busy=1 from the next cycle.
  - div_load while div_busy=1 is ignored.
  - The pending divisor is applied on the first enabled wrap (cnt_next==0) after capture. The wrap uses the old N; H for the new period uses the new N. div_busy clears in that same cycle.
  - A load in the same cycle as a wrap is applied at the following wrap.
  - Loading a value equal to the current N still completes the handshake.
- Frame counter:
  - On each rise_tick, if frame_cnt == L-1: frame_cnt <= 0, frame_tick=1, and L <= frame_len (0 -> 1).
  - Otherwise frame_cnt <= frame_cnt+1.
  - frame_len changes therefore take effect only at a frame boundary.
- Widths: all comparisons unsigned; cnt is DIV_W bits and never exceeds N-1; frame_cnt is FRAME_W bits.
- Legal divisor range: 2 .. 2^DIV_W-1.

Optional Feature:
- Macro CLK_DIVIDER_PROG_SYNC_EN.
- Defined: adds input sync_in (1 bit). sync_in=1 with enable=1 forces cnt_next=0, regardless of current cnt:
  - rise_tick=1 and clk_out=1 next cycle;
  - any pending divisor is applied and div_busy cleared;
  - frame_cnt <= 0 with frame_tick=0 (frame_tick=1 if L=1).
  - sync_in has priority over the normal wrap. Purpose: phase-align several dividers to one event.
- Undefined: no sync_in port; behaviour exactly as above.

Test Plan:
- Release reset with DIV_DEFAULT=2, enable=1 -> clk_out toggles every cycle starting with 1; rise_tick on every high cycle; fall_tick on every low cycle.
- Load div_value=5 -> div_busy=1 next cycle; clears on the next wrap; afterwards clk_out repeats 1,1,1,0,0, with fall_tick on the first 0.
- Load div_value=0, then 1 -> both behave as N=2. A div_load while div_busy=1 leaves the pending value unchanged.
- N=4, frame_len=3 -> frame_tick on every 3rd rise_tick (every 12 cycles). Change frame_len to 2 mid-frame -> takes effect only after the current 3-period frame completes.
- Drop enable for 7 cycles mid-high-phase -> clk_out holds 1, no ticks; resumes at the same cnt. Assert reset=0 mid-period with a divisor pending -> all outputs 0, div_busy=0, N back to DIV_DEFAULT.
- With CLK_DIVIDER_PROG_SYNC_EN, N=6 and a sync_in pulse at cnt=3 -> clk_out=1 and rise_tick=1 the next cycle, and a full 6-cycle period follows.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable clock divider with registered clk_out,
// single-cycle rise/fall strobes and a frame strobe every L output periods.
// Optional feature macro: CLK_DIVIDER_PROG_SYNC_EN adds i_sync_in, which forces a
// period restart (phase alignment of several dividers to one event).
module clk_divider_prog #(
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned DIV_DEFAULT   = 2,
    parameter int unsigned FRAME_W       = 16,
    parameter int unsigned FRAME_DEFAULT = 256
) (
    input  logic               i_clk_in,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [DIV_W-1:0]   i_div_value,
    input  logic               i_div_load,
    output logic               o_div_busy,
    input  logic [FRAME_W-1:0] i_frame_len,
`ifdef CLK_DIVIDER_PROG_SYNC_EN
    input  logic               i_sync_in,
`endif
    output logic               o_clk_out,
    output logic               o_rise_tick,
    output logic               o_fall_tick,
    output logic               o_frame_tick
);

    // Reset divisor and frame length after clamping.
    localparam int unsigned N0_INT = (DIV_DEFAULT < 2) ? 2 : DIV_DEFAULT;
    localparam int unsigned L0_INT = (FRAME_DEFAULT == 0) ? 1 : FRAME_DEFAULT;

    localparam logic [DIV_W-1:0]   N0        = DIV_W'(N0_INT);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]   DIV_TWO   = DIV_W'(2);
    localparam logic [DIV_W:0]     HIGH_ONE  = (DIV_W + 1)'(1);
    localparam logic [FRAME_W-1:0] L0        = FRAME_W'(L0_INT);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_n;
    logic [DIV_W-1:0]   r_pend;
    logic               r_busy;
    logic               r_clk;
    logic               r_rise;
    logic               r_fall;
    logic               r_frame_tick;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] r_len;

    logic               w_sync;
    logic               w_wrap;
    logic               w_apply;
    logic [DIV_W-1:0]   w_cnt_next;
    logic [DIV_W-1:0]   w_n_next;
    logic [DIV_W:0]     w_high;
    logic [DIV_W-1:0]   w_div_eff;
    logic [FRAME_W-1:0] w_len_eff;

`ifdef CLK_DIVIDER_PROG_SYNC_EN
    assign w_sync = i_sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // Next count, divisor switch at the wrap, and high time of the coming period.
    always_comb begin
        w_wrap     = w_sync || (r_cnt == (r_n - DIV_ONE));
        w_cnt_next = w_wrap ? '0 : (r_cnt + DIV_ONE);
        w_apply    = w_wrap && r_busy;
        w_n_next   = w_apply ? r_pend : r_n;
        // Widened by one bit so N = 2^DIV_W-1 cannot overflow the +1.
        w_high     = ({1'b0, w_n_next} + HIGH_ONE) >> 1;
        w_div_eff  = (i_div_value < DIV_TWO) ? DIV_TWO : i_div_value;
        w_len_eff  = (i_frame_len == '0) ? FRAME_ONE : i_frame_len;
    end

    // Period counter, active divisor and registered clock/edge strobes.
    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_cnt  <= N0 - DIV_ONE;
            r_n    <= N0;
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (i_enable) begin
            r_cnt  <= w_cnt_next;
            r_n    <= w_n_next;
            r_clk  <= ({1'b0, w_cnt_next} < w_high);
            r_rise <= w_wrap;
            r_fall <= ({1'b0, w_cnt_next} == w_high);
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    // Divisor load handshake; loads are accepted even while disabled.
    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_pend <= '0;
            r_busy <= 1'b0;
        end else if (i_enable && w_apply) begin
            r_busy <= 1'b0;
        end else if (i_div_load && !r_busy) begin
            r_pend <= w_div_eff;
            r_busy <= 1'b1;
        end
    end

    // Frame counter advances on each rise; frame_len is sampled only at a frame boundary.
    always_ff @(posedge i_clk_in) begin
        if (!i_reset) begin
            r_frame_cnt  <= '0;
            r_len        <= L0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (i_enable && w_wrap) begin
                if (w_sync && (r_len != FRAME_ONE)) begin
                    // Realignment restarts the frame without closing it.
                    r_frame_cnt <= '0;
                end else if (r_frame_cnt == (r_len - FRAME_ONE)) begin
                    r_frame_cnt  <= '0;
                    r_frame_tick <= 1'b1;
                    r_len        <= w_len_eff;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FRAME_ONE;
                end
            end
        end
    end

    assign o_clk_out    = r_clk;
    assign o_rise_tick  = r_rise;
    assign o_fall_tick  = r_fall;
    assign o_frame_tick = r_frame_tick;
    assign o_div_busy   = r_busy;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Table-driven bench for clk_divider_prog: one record per clock cycle with the
// inputs applied before the edge and the outputs expected just after it.
module tb_clk_divider_prog;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        ld;
        logic [7:0]  dv;
        logic [15:0] fl;
        logic        sync;
        logic [4:0]  exp; // {clk_out, rise_tick, fall_tick, frame_tick, div_busy}
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  div_value;
    logic        div_load;
    logic        div_busy;
    logic [15:0] frame_len;
    logic        sync_in;
    logic        clk_out;
    logic        rise_tick;
    logic        fall_tick;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    clk_divider_prog #(
        .DIV_W         (8),
        .DIV_DEFAULT   (2),
        .FRAME_W       (16),
        .FRAME_DEFAULT (3)
    ) dut (
        .i_clk_in     (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_div_value  (div_value),
        .i_div_load   (div_load),
        .o_div_busy   (div_busy),
        .i_frame_len  (frame_len),
`ifdef CLK_DIVIDER_PROG_SYNC_EN
        .i_sync_in    (sync_in),
`endif
        .o_clk_out    (clk_out),
        .o_rise_tick  (rise_tick),
        .o_fall_tick  (fall_tick),
        .o_frame_tick (frame_tick)
    );

    task automatic add(input logic r, input logic e, input logic l, input logic [7:0] d,
                       input logic [15:0] f, input logic s, input logic [4:0] x);
        vec_t v;
        v.rst_n = r; v.en = e; v.ld = l; v.dv = d; v.fl = f; v.sync = s; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %b, expected %b", name, idx, act, req);
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        div_value = '0;
        div_load  = 1'b0;
        frame_len = 16'd3;
        sync_in   = 1'b0;

        // Reset (a load during reset is ignored), then N=2 toggling, frame of 3.
        add(0,1,1,7,3,0,5'b00000); add(0,1,0,0,3,0,5'b00000);
        add(1,1,0,0,3,0,5'b11000); add(1,1,0,0,3,0,5'b00100);
        add(1,1,0,0,3,0,5'b11000); add(1,1,0,0,3,0,5'b00100);
        add(1,1,0,0,3,0,5'b11010); add(1,1,0,0,3,0,5'b00100);
        // Load 5 on a wrap cycle: applied at the following wrap -> 1,1,1,0,0.
        add(1,1,1,5,3,0,5'b11001); add(1,1,0,0,3,0,5'b00101);
        add(1,1,0,0,3,0,5'b11000); add(1,1,0,0,3,0,5'b10000);
        add(1,1,0,0,3,0,5'b10000); add(1,1,0,0,3,0,5'b00100);
        add(1,1,0,0,3,0,5'b00000); add(1,1,0,0,3,0,5'b11010);
        // Load 0 (clamped to 2), then load 4 while busy (ignored).
        add(1,1,1,0,3,0,5'b10001); add(1,1,1,4,3,0,5'b10001);
        add(1,1,0,0,3,0,5'b00101); add(1,1,0,0,3,0,5'b00001);
        add(1,1,0,0,3,0,5'b11000); add(1,1,0,0,3,0,5'b00100);
        add(1,1,0,0,3,0,5'b11000);
        // Load 1 (clamped to 2, same as current N) still completes the handshake.
        add(1,1,1,1,3,0,5'b00101); add(1,1,0,0,3,0,5'b11010);
        // N=4; frame_len changed to 2 mid-frame, effective after the 3-period frame.
        add(1,1,1,4,3,0,5'b00101); add(1,1,0,0,3,0,5'b11000);
        add(1,1,0,0,3,0,5'b10000); add(1,1,0,0,3,0,5'b00100);
        add(1,1,0,0,3,0,5'b00000); add(1,1,0,0,3,0,5'b11000);
        add(1,1,0,0,2,0,5'b10000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b00000); add(1,1,0,0,2,0,5'b11010);
        add(1,1,0,0,2,0,5'b10000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b00000); add(1,1,0,0,2,0,5'b11000);
        add(1,1,0,0,2,0,5'b10000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b00000); add(1,1,0,0,2,0,5'b11010);
        // Freeze for 7 cycles in the high phase; a load is taken while frozen.
        add(1,1,0,0,2,0,5'b10000);
        add(1,0,0,0,2,0,5'b10000); add(1,0,0,0,2,0,5'b10000);
        add(1,0,1,3,2,0,5'b10001); add(1,0,0,0,2,0,5'b10001);
        add(1,0,0,0,2,0,5'b10001); add(1,0,0,0,2,0,5'b10001);
        add(1,0,0,0,2,0,5'b10001);
        add(1,1,0,0,2,0,5'b00101);
        // Reset mid-period with 3 pending: back to N=2 and L=3.
        add(0,1,0,0,2,0,5'b00000);
        add(1,1,0,0,2,0,5'b11000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b11000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b11010);
`ifdef CLK_DIVIDER_PROG_SYNC_EN
        // N=6, sync at cnt=3: immediate rise, no frame tick, then a full period.
        add(0,1,0,0,2,0,5'b00000);
        add(1,1,1,6,2,0,5'b11001); add(1,1,0,0,2,0,5'b00101);
        add(1,1,0,0,2,0,5'b11000); add(1,1,0,0,2,0,5'b10000);
        add(1,1,0,0,2,0,5'b10000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,1,5'b11000); add(1,1,0,0,2,0,5'b10000);
        add(1,1,0,0,2,0,5'b10000); add(1,1,0,0,2,0,5'b00100);
        add(1,1,0,0,2,0,5'b00000); add(1,1,0,0,2,0,5'b00000);
        add(1,1,0,0,2,0,5'b11000);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            logic [4:0] x;
            @(negedge clk);
            reset     = vecs[i].rst_n;
            enable    = vecs[i].en;
            div_load  = vecs[i].ld;
            div_value = vecs[i].dv;
            frame_len = vecs[i].fl;
            sync_in   = vecs[i].sync;
            @(posedge clk);
            #1;
            x = vecs[i].exp;
            chk("clk_out",    i, clk_out,    x[4]);
            chk("rise_tick",  i, rise_tick,  x[3]);
            chk("fall_tick",  i, fall_tick,  x[2]);
            chk("frame_tick", i, frame_tick, x[1]);
            chk("div_busy",   i, div_busy,   x[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
